// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, FSM encoding and row helpers for the keypad scanner
package keypad_pkg;
    localparam int N_ROW = 4;
    localparam int N_COL = 4;
    localparam int KEY_W = 4;
    localparam logic [3:0] ALL_HIGH = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESENT  = 2'd2,
        ST_WAIT_REL = 2'd3
    } kp_state_e;

    // True when exactly one row is pulled low; ghosting/multi-key patterns fail.
    function automatic logic one_low(input logic [3:0] rows);
        logic [3:0] z;
        z = ~rows;
        return (z != 4'h0) && ((z & (z - 4'h1)) == 4'h0);
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// rtl/keypad_scan_ctrl_if.sv - key code valid/ack handshake toward the consumer
interface keypad_scan_ctrl_if import keypad_pkg::*; ();
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ack;

    modport master (output key_code, output key_valid, input key_ack);
    modport slave  (input key_code, input key_valid, output key_ack);
endinterface

// File: rtl/kp_tick_gen.sv
// rtl/kp_tick_gen.sv - scan prescaler producing one-cycle ticks every CLK_DIV clocks
module kp_tick_gen #(
    parameter logic [15:0] CLK_DIV = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    logic [15:0] cnt_q, cnt_d;
    logic        wrap;

    assign wrap = (cnt_q == CLK_DIV - 16'd1);
    assign tick = wrap && !clr;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clr || wrap) cnt_d = 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with debounce and valid/ack key output
module keypad_scan_ctrl import keypad_pkg::*; #(
    parameter logic [15:0] CLK_DIV        = 16'd50000,
    parameter logic [7:0]  DEBOUNCE_TICKS = 8'd4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [3:0]                 in_row,
    output logic [3:0]                 out_col,
    output logic                       busy,
    keypad_scan_ctrl_if.master         key_if
);
    kp_state_e   state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [1:0]  row_q, row_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic [3:0]  out_col_q, out_col_d;
    logic [3:0]  rows_s1_q, rows_s_q;
    logic        tick;
    logic        advance;

    kp_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!en),
        .tick  (tick)
    );

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = valid_q;
        advance   = 1'b0;
        if (!en) begin
            state_d   = ST_SCAN;
            col_idx_d = 2'd0;
            valid_d   = 1'b0;
            cnt_d     = 8'd0;
        end else begin
            case (state_q)
                ST_SCAN: if (tick) begin
                    if (one_low(rows_s_q)) begin
                        row_d   = low_row(rows_s_q);
                        cnt_d   = 8'd0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_DEBOUNCE: if (tick) begin
                    if (rows_s_q == ~(4'b0001 << row_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEBOUNCE_TICKS) begin
                            code_d  = {row_q, col_idx_q};
                            valid_d = 1'b1;
                            state_d = ST_PRESENT;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        advance = 1'b1;
                    end
                end
                // Release is deliberately not watched here: the consumer must ack first.
                ST_PRESENT: if (valid_q && key_if.key_ack) begin
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT_REL;
                end
                ST_WAIT_REL: if (tick) begin
                    if (rows_s_q == ALL_HIGH) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEBOUNCE_TICKS) begin
                            state_d = ST_SCAN;
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
        if (advance) col_idx_d = col_idx_q + 2'd1;
        out_col_d = en ? ~(4'b0001 << col_idx_d) : ALL_HIGH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            row_q     <= 2'd0;
            cnt_q     <= 8'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            out_col_q <= ALL_HIGH;
            rows_s1_q <= ALL_HIGH;
            rows_s_q  <= ALL_HIGH;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            out_col_q <= out_col_d;
            rows_s1_q <= in_row;
            rows_s_q  <= rows_s1_q;
        end
    end

    assign out_col          = out_col_q;
    assign busy             = (state_q != ST_SCAN);
    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
endmodule
